// File: rtl/fib_term_buffer.sv
// Fibonacci consumer stage: tags accepted terms with a saturating index, stops on
// wrap-around (term smaller than its predecessor) and buffers tagged terms in a FIFO.
module fib_term_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [IDX_WIDTH-1:0]    out_index,
    input  logic                    out_ready,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     FULL    = CNT_W'(DEPTH);
    localparam logic [IDX_WIDTH-1:0] IDX_MAX = '1;

    function automatic logic [IDX_WIDTH-1:0] sat_inc(input logic [IDX_WIDTH-1:0] v);
        return (v == IDX_MAX) ? v : v + IDX_WIDTH'(1);
    endfunction

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [IDX_WIDTH-1:0]  mem_idx  [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] prev;
    logic [IDX_WIDTH-1:0]  next_idx;
    logic                  ovf;

    logic push_cand;
    logic wrap;
    logic push;
    logic pop;

    // in_ready is a function of registered state only, so no path from out_ready
    assign in_ready  = (cnt != FULL) && !ovf;
    assign out_valid = (cnt != '0);
    assign push_cand = in_valid && in_ready;
    assign wrap      = push_cand && (in_data < prev);
    assign push      = push_cand && !wrap;
    assign pop       = out_valid && out_ready;

    assign out_data  = mem_data[rd_ptr];
    assign out_index = mem_idx[rd_ptr];
    assign overflow  = ovf;
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            prev     <= '0;
            next_idx <= '0;
            ovf      <= 1'b0;
        end else begin
            if (wrap) begin
                ovf <= 1'b1;
            end
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                prev     <= in_data;
                next_idx <= sat_inc(next_idx);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_idx[wr_ptr]  <= next_idx;
        end
    end

endmodule

// File: tb/tb_fib_term_buffer.sv
// Randomized and directed bench for fib_term_buffer against a queue-based
// reference model of the tagging / overflow / buffering rules.
module tb_fib_term_buffer;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int DEPTH = 4;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          out_ready;
    logic          overflow;
    logic [2:0]    count;

    fib_term_buffer #(.DATA_WIDTH(DW), .IDX_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_index(out_index), .out_ready(out_ready), .overflow(overflow),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int idx;
    } ent_t;

    ent_t q[$];
    int   m_prev;
    int   m_idx;
    bit   m_ovf;
    int   n_pops;
    bit   took;
    int   n_checks;
    int   n_errors;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_prev = 0;
        m_idx  = 0;
        m_ovf  = 1'b0;
    endfunction

    // Compare DUT against the model, advance the model with the current inputs, clock once.
    task automatic cycle();
        bit mr;
        mr = (q.size() < DEPTH) && !m_ovf;
        check_eq("out_valid", int'(out_valid), int'(q.size() != 0));
        if (q.size() != 0) begin
            check_eq("out_data", int'(out_data), q[0].data);
            check_eq("out_index", int'(out_index), q[0].idx);
        end
        check_eq("in_ready", int'(in_ready), int'(mr));
        check_eq("overflow", int'(overflow), int'(m_ovf));
        check_eq("count", int'(count), q.size());
        took = 1'b0;
        if (!resetn) begin
            model_reset();
        end else begin
            if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
                n_pops++;
            end
            if (in_valid && mr) begin
                took = 1'b1;
                if (int'(in_data) < m_prev) begin
                    m_ovf = 1'b1;
                end else begin
                    q.push_back('{data: int'(in_data), idx: m_idx});
                    m_prev = int'(in_data);
                    if (m_idx != (1 << IW) - 1) m_idx++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int term);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = DW'(term);
        for (int i = 0; i < 50 && !done; i++) begin
            cycle();
            done = took;
        end
        in_valid = 1'b0;
        if (!done) check_eq("feed_timeout", 0, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle();
        check_eq("drain_empty", q.size(), 0);
        cycle();
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        for (int i = 0; i < cycles; i++) cycle();
        resetn = 1'b1;
    endtask

    int fib[14];
    int pops0;
    int cur;
    bit pending;

    initial begin
        n_checks = 0; n_errors = 0; n_pops = 0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; resetn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset
        do_reset(1);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_overflow", int'(overflow), 0);
        check_eq("rst_in_ready", int'(in_ready), 1);

        // Streaming with a ready sink
        out_ready = 1'b1;
        foreach (fib[i]) fib[i] = (i < 2) ? 1 : fib[i-1] + fib[i-2];
        for (int i = 0; i < 6; i++) begin
            feed(fib[i]);
            check_eq("stream_count_le1", int'(count <= 3'd1), 1);
        end
        drain();

        // Backpressure
        do_reset(1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed(fib[i]);
        check_eq("bp_count_full", int'(count), 4);
        check_eq("bp_in_ready", int'(in_ready), 0);
        in_valid = 1'b1; in_data = 8'd5;
        cycle();
        cycle();
        check_eq("bp_head_index", int'(out_index), 0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check_eq("bp_head_after_pop", int'(out_data), 1);
        check_eq("bp_head_idx_after_pop", int'(out_index), 1);
        feed(5);
        check_eq("bp_count_refill", int'(count), 4);
        drain();

        // Wrap at 8 bits: 1..233 then 377 mod 256 = 121
        do_reset(1);
        pops0 = n_pops;
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) feed(fib[i]);
        feed(121);
        cycle();
        check_eq("wrap_overflow", int'(overflow), 1);
        check_eq("wrap_in_ready", int'(in_ready), 0);
        in_valid = 1'b1; in_data = 8'd250;
        cycle();
        in_valid = 1'b0;
        drain();
        check_eq("wrap_drained_terms", n_pops - pops0, 13);
        check_eq("wrap_overflow_sticky", int'(overflow), 1);

        // Concurrent push and pop at count 2
        do_reset(1);
        out_ready = 1'b0;
        feed(1);
        feed(2);
        check_eq("cc_count_before", int'(count), 2);
        out_ready = 1'b1;
        feed(3);
        out_ready = 1'b0;
        check_eq("cc_count_after", int'(count), 2);
        check_eq("cc_head", int'(out_data), 2);
        drain();

        // Mid-operation reset with count 3 and overflow set
        do_reset(1);
        out_ready = 1'b0;
        feed(1); feed(2); feed(3);
        feed(1);
        cycle();
        check_eq("mr_count3", int'(count), 3);
        check_eq("mr_ovf_set", int'(overflow), 1);
        do_reset(1);
        check_eq("mr_count0", int'(count), 0);
        check_eq("mr_ovf_clear", int'(overflow), 0);
        feed(7);
        check_eq("mr_first_index", int'(out_index), 0);
        drain();

        // Randomized traffic with occasional drops, resets, and index saturation
        cur = 0;
        pending = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!pending && ($urandom % 4) != 0) begin
                pending = 1'b1;
                if (($urandom % 80) == 0 && cur > 0) cur = cur - 1 - int'($urandom % cur);
                else cur = (cur + int'($urandom_range(0, 3))) % 256;
            end
            in_valid  = pending;
            in_data   = DW'(cur);
            out_ready = ($urandom % 3) != 0;
            resetn    = ($urandom % 500) != 0;
            cycle();
            if (took || !resetn) pending = 1'b0;
            if (!resetn) cur = 0;
        end
        resetn = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
